// File: rtl/ysyx_210544_mdu_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, W-form flag position and FSM states.
package ysyx_210544_mdu_pkg;

  localparam logic [2:0] MDU_MUL    = 3'd0;
  localparam logic [2:0] MDU_MULH   = 3'd1;
  localparam logic [2:0] MDU_MULHSU = 3'd2;
  localparam logic [2:0] MDU_MULHU  = 3'd3;
  localparam logic [2:0] MDU_DIV    = 3'd4;
  localparam logic [2:0] MDU_DIVU   = 3'd5;
  localparam logic [2:0] MDU_REM    = 3'd6;
  localparam logic [2:0] MDU_REMU   = 3'd7;
  localparam int         MDU_W_BIT  = 3;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_BUSY = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/ysyx_210544_mdu_div.sv
// Restoring divider datapath on unsigned magnitudes: one quotient bit per step_i.
// Latency: 1 cycle per step; next-state outputs let the owner capture the final step's result on the same edge.
// Backpressure: none, stepping is fully controlled by the owner.
module ysyx_210544_mdu_div #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            step_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quot_d_o,
  output logic [XLEN-1:0] rem_d_o
);

  logic [XLEN-1:0] quot_q, rem_q, dsor_q;
  logic [XLEN:0]   shifted;

  // Partial remainder only ever holds values below the divisor, so XLEN bits suffice;
  // the one extra bit of the shifted value catches the case where it overflows XLEN.
  always_comb begin
    shifted = {rem_q, quot_q[XLEN-1]};
    if (shifted >= {1'b0, dsor_q}) begin
      rem_d_o  = XLEN'(shifted - {1'b0, dsor_q});
      quot_d_o = {quot_q[XLEN-2:0], 1'b1};
    end else begin
      rem_d_o  = shifted[XLEN-1:0];
      quot_d_o = {quot_q[XLEN-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quot_q <= '0;
      rem_q  <= '0;
      dsor_q <= '0;
    end else if (load_i) begin
      quot_q <= dividend_i;
      rem_q  <= '0;
      dsor_q <= divisor_i;
    end else if (step_i) begin
      quot_q <= quot_d_o;
      rem_q  <= rem_d_o;
    end
  end

endmodule

// File: rtl/ysyx_210544_mdu.sv
// RV64M multiply/divide unit (shift-add multiply, restoring divide); optional YSYX_210544_MDU_FAST_MUL_EN single-edge multiply.
// Latency N+1 edges (N=32 for W forms, else XLEN); div-by-zero, MIN/-1 and fast multiplies finish in 1 edge.
// Result held in DONE until i_ack; i_start only taken in IDLE; i_flush aborts from any state.
module ysyx_210544_mdu
  import ysyx_210544_mdu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_start,
  input  logic [3:0]      i_op,
  input  logic [XLEN-1:0] i_op1,
  input  logic [XLEN-1:0] i_op2,
  input  logic            i_flush,
  input  logic            i_ack,
  output logic            o_ready,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam int WSH   = XLEN - 32;

  // Extends the low word to XLEN (signed or zero) for W forms; full-width values pass through.
  function automatic logic [XLEN-1:0] wext(input logic [XLEN-1:0] v, input logic w, input logic sgn);
    logic [XLEN-1:0] r;
    r = v << WSH;
    if (!w) return v;
    if (sgn) return $signed(r) >>> WSH;
    return r >> WSH;
  endfunction

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       op_q;
  logic             neg_q;
  logic [XLEN-1:0]  result_q;
  logic             w_q;

  logic             accept, last, start_done;
  logic             in_w, in_div, in_s1, in_s2, in_neg_a, in_neg_b, in_neg;
  logic             in_dz, in_ovf, in_special;
  logic [XLEN-1:0]  in_a, in_b, in_mag_a, in_mag_b, min_v, special_raw, start_res;
  logic [XLEN-1:0]  fast_res, mul_res, div_res, div_val;
  logic [XLEN-1:0]  div_quot_d, div_rem_d;
  logic             unused_op;

  assign unused_op = ^op_q;
  assign w_q       = op_q[MDU_W_BIT] && (XLEN == 64);

  always_comb begin
    in_w     = i_op[MDU_W_BIT] && (XLEN == 64);
    in_div   = i_op[2];
    in_s1    = in_div ? !i_op[0] : (i_op[2:0] != MDU_MULHU);
    in_s2    = in_div ? !i_op[0] : (i_op[2:0] == MDU_MUL || i_op[2:0] == MDU_MULH);
    in_a     = wext(i_op1, in_w, in_s1);
    in_b     = wext(i_op2, in_w, in_s2);
    in_neg_a = in_s1 & in_a[XLEN-1];
    in_neg_b = in_s2 & in_b[XLEN-1];
    in_mag_a = in_neg_a ? -in_a : in_a;
    in_mag_b = in_neg_b ? -in_b : in_b;
    // Remainder takes the dividend's sign; everything else the product/quotient sign.
    in_neg   = (in_div && i_op[1]) ? in_neg_a : (in_neg_a ^ in_neg_b);
    min_v    = in_w ? ({XLEN{1'b1}} << 31) : {1'b1, {(XLEN-1){1'b0}}};
    in_dz    = in_div && (in_b == '0);
    in_ovf   = in_div && !i_op[0] && (in_a == min_v) && (in_b == '1);
    in_special = in_dz || in_ovf;
    if (in_dz) special_raw = i_op[1] ? in_a : '1;
    else       special_raw = i_op[1] ? '0 : in_a;
    start_res = in_special ? wext(special_raw, in_w, 1'b1) : fast_res;
  end

`ifdef YSYX_210544_MDU_FAST_MUL_EN
  localparam bit FastMul = 1'b1;
  logic signed [XLEN:0]     fm_a, fm_b;
  logic signed [2*XLEN+1:0] fm_p;
  logic                     unused_fm;

  assign fm_a      = $signed({in_neg_a, in_a});
  assign fm_b      = $signed({in_neg_b, in_b});
  assign fm_p      = fm_a * fm_b;
  assign unused_fm = ^fm_p[2*XLEN+1:2*XLEN];
  assign fast_res  = wext((i_op[2:0] == MDU_MUL) ? fm_p[XLEN-1:0] : fm_p[2*XLEN-1:XLEN], in_w, 1'b1);
  assign mul_res   = '0;
`else
  localparam bit FastMul = 1'b0;
  logic [2*XLEN-1:0] acc_q, mcand_q, acc_nxt, prod;
  logic [XLEN-1:0]   mplier_q;

  assign acc_nxt  = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign prod     = neg_q ? -acc_nxt : acc_nxt;
  assign mul_res  = wext((op_q[2:0] == MDU_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN], w_q, 1'b1);
  assign fast_res = '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (accept) begin
      acc_q    <= '0;
      mcand_q  <= {{XLEN{1'b0}}, in_mag_a};
      mplier_q <= in_mag_b;
    end else if (state_q == MDU_BUSY && !op_q[2]) begin
      acc_q    <= acc_nxt;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
    end
  end
`endif

  assign start_done = in_special || (FastMul && !in_div);

  // W-form dividends are left-aligned so 32 steps consume exactly their 32 significant bits.
  ysyx_210544_mdu_div #(.XLEN(XLEN)) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (accept && in_div),
    .step_i     (state_q == MDU_BUSY && op_q[2]),
    .dividend_i (in_w ? (in_mag_a << WSH) : in_mag_a),
    .divisor_i  (in_mag_b),
    .quot_d_o   (div_quot_d),
    .rem_d_o    (div_rem_d)
  );

  always_comb begin
    div_val = op_q[1] ? div_rem_d : div_quot_d;
    div_res = wext(neg_q ? -div_val : div_val, w_q, 1'b1);
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    last    = 1'b0;
    if (i_flush) begin
      state_d = MDU_IDLE;
    end else begin
      case (state_q)
        MDU_IDLE: if (i_start) begin
          accept  = 1'b1;
          state_d = start_done ? MDU_DONE : MDU_BUSY;
        end
        MDU_BUSY: if (cnt_q == CNT_W'(1)) begin
          last    = 1'b1;
          state_d = MDU_DONE;
        end
        MDU_DONE: if (i_ack) state_d = MDU_IDLE;
        default:  state_d = MDU_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= MDU_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else if (accept) begin
      op_q     <= i_op;
      cnt_q    <= in_w ? CNT_W'(32) : CNT_W'(XLEN);
      neg_q    <= in_neg;
      if (start_done) result_q <= start_res;
    end else if (state_q == MDU_BUSY) begin
      cnt_q <= cnt_q - CNT_W'(1);
      if (last) result_q <= op_q[2] ? div_res : mul_res;
    end
  end

  assign o_ready  = (state_q == MDU_IDLE);
  assign o_valid  = (state_q == MDU_DONE);
  assign o_result = result_q;

endmodule

// File: tb/tb_ysyx_210544_mdu.sv
// Randomized and directed checks of ysyx_210544_mdu against a plain-arithmetic RV64M model.
module tb_ysyx_210544_mdu;

  localparam int XLEN = 64;
`ifdef YSYX_210544_MDU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 65;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            i_start = 1'b0;
  logic [3:0]      i_op = 4'd0;
  logic [XLEN-1:0] i_op1 = '0;
  logic [XLEN-1:0] i_op2 = '0;
  logic            i_flush = 1'b0;
  logic            i_ack = 1'b0;
  logic            o_ready, o_valid;
  logic [XLEN-1:0] o_result;

  int checks = 0;
  int errors = 0;

  ysyx_210544_mdu #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_op(i_op), .i_op1(i_op1), .i_op2(i_op2),
    .i_flush(i_flush), .i_ack(i_ack), .o_ready(o_ready), .o_valid(o_valid), .o_result(o_result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Architectural result of one op, plus whether it is a 1-edge special case.
  function automatic logic [63:0] model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                                        output bit special);
    logic [127:0] p;
    logic [31:0]  a32, b32, r32;
    logic signed [31:0] sa32, sb32;
    logic signed [63:0] sa, sb;
    special = 0;
    a32 = a[31:0]; b32 = b[31:0]; sa32 = a32; sb32 = b32; sa = a; sb = b;
    if (op[3]) begin
      r32 = 32'd0;
      case (op[2:0])
        3'd0: r32 = a32 * b32;
        3'd4, 3'd6: begin
          if (b32 == 0) begin special = 1; r32 = op[1] ? a32 : 32'hFFFF_FFFF; end
          else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin special = 1; r32 = op[1] ? 32'd0 : a32; end
          else if (op[1]) r32 = sa32 % sb32;
          else r32 = sa32 / sb32;
        end
        3'd5, 3'd7: begin
          if (b32 == 0) begin special = 1; r32 = op[1] ? a32 : 32'hFFFF_FFFF; end
          else r32 = op[1] ? a32 % b32 : a32 / b32;
        end
        default: r32 = 32'd0;
      endcase
      return {{32{r32[31]}}, r32};
    end
    case (op[2:0])
      3'd0: return a * b;
      3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
      3'd2: begin p = {{64{a[63]}}, a} * {64'd0, b}; return p[127:64]; end
      3'd3: begin p = {64'd0, a} * {64'd0, b}; return p[127:64]; end
      3'd4, 3'd6: begin
        if (b == 0) begin special = 1; return op[1] ? a : '1; end
        if (a == 64'h8000_0000_0000_0000 && b == '1) begin special = 1; return op[1] ? 64'd0 : a; end
        if (op[1]) return sa % sb;
        return sa / sb;
      end
      default: begin
        if (b == 0) begin special = 1; return op[1] ? a : '1; end
        return op[1] ? a % b : a / b;
      end
    endcase
  endfunction

  // Issues one op, checks latency and result, holds i_ack low for `hold` cycles, then acks
  // with a competing i_start that must be ignored.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input int exp_lat, input int hold);
    int lat;
    @(negedge clk);
    check({tag, "_rdy"}, 64'(o_ready), 64'd1);
    i_op = op; i_op1 = a; i_op2 = b; i_start = 1'b1;
    @(posedge clk); #1; i_start = 1'b0; lat = 1;
    while (!o_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_res"}, o_result, exp);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check({tag, "_hold"}, {o_result[62:0], o_valid}, {exp[62:0], 1'b1});
    end
    @(negedge clk);
    i_ack = 1'b1; i_start = 1'b1;
    @(posedge clk); #1;
    i_ack = 1'b0; i_start = 1'b0;
    check({tag, "_ack"}, {62'd0, o_ready, o_valid}, 64'd2);
  endtask

  task automatic run_rand(input string tag, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                          input int hold);
    bit sp;
    logic [63:0] exp;
    int lat;
    exp = model(op, a, b, sp);
    if (sp) lat = 1;
    else if (!op[2]) lat = op[3] ? ((MUL_LAT == 1) ? 1 : 33) : MUL_LAT;
    else lat = op[3] ? 33 : 65;
    run_op(tag, op, a, b, exp, lat, hold);
  endtask

  function automatic logic [63:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return {$urandom(), $urandom()};
      1: return 64'($urandom_range(0, 20));
      2: return 64'd0;
      3: return '1;
      4: return 64'h8000_0000_0000_0000;
      default: return {{32{$urandom_range(0, 1) == 1}}, $urandom()};
    endcase
  endfunction

  logic [3:0] legal_ops [13] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd12, 4'd13, 4'd14, 4'd15};

  initial begin
    #2 rst_n = 1'b0;
    #20;
    check("rst_ready", 64'(o_ready), 64'd1);
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_result", o_result, 64'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op("mul",    4'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, MUL_LAT, 0);
    run_op("mulhu",  4'd3, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, MUL_LAT, 0);
    run_op("mulhsu", 4'd2, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, MUL_LAT, 0);
    run_op("div",    4'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, 0);
    run_op("rem",    4'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0);
    run_op("divu",   4'd5, 64'd100, 64'd7, 64'd14, 65, 0);
    run_op("divu0",  4'd5, 64'd5, 64'd0, '1, 1, 0);
    run_op("remu0",  4'd7, 64'd5, 64'd0, 64'd5, 1, 0);
    run_op("divovf", 4'd4, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1, 0);
    run_op("removf", 4'd6, 64'h8000_0000_0000_0000, '1, 64'd0, 1, 0);
    run_op("divw",   4'd12, 64'h0000_0001_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 33, 5);

    // Flush at BUSY cycle 10, with a competing i_start that must be dropped.
    @(negedge clk);
    i_op = 4'd5; i_op1 = 64'd100; i_op2 = 64'd7; i_start = 1'b1;
    @(posedge clk); #1; i_start = 1'b0;
    for (int k = 0; k < 9; k++) begin @(posedge clk); #1; end
    check("busy_ready", 64'(o_ready), 64'd0);
    @(negedge clk); i_flush = 1'b1; i_start = 1'b1;
    @(posedge clk); #1; i_flush = 1'b0; i_start = 1'b0;
    check("flush_busy", {62'd0, o_ready, o_valid}, 64'd2);
    for (int k = 0; k < 70; k++) begin @(posedge clk); #1; end
    check("flush_quiet", {62'd0, o_ready, o_valid}, 64'd2);

    // Flush while DONE drops the pending result.
    @(negedge clk); i_op = 4'd5; i_op1 = 64'd9; i_op2 = 64'd0; i_start = 1'b1;
    @(posedge clk); #1; i_start = 1'b0;
    check("done_valid", 64'(o_valid), 64'd1);
    @(negedge clk); i_flush = 1'b1;
    @(posedge clk); #1; i_flush = 1'b0;
    check("flush_done", {62'd0, o_ready, o_valid}, 64'd2);

    for (int n = 0; n < 40; n++) begin
      logic [3:0] op;
      op = legal_ops[$urandom_range(0, 12)];
      run_rand($sformatf("rnd%0d_op%0d", n, op), op, pick_operand(), pick_operand(), $urandom_range(0, 2));
    end

    // Asynchronous reset in the middle of a divide.
    @(negedge clk); i_op = 4'd4; i_op1 = 64'd12345; i_op2 = 64'd3; i_start = 1'b1;
    @(posedge clk); #1; i_start = 1'b0;
    for (int k = 0; k < 20; k++) begin @(posedge clk); #1; end
    rst_n = 1'b0; #1;
    check("arst_ready", 64'(o_ready), 64'd1);
    check("arst_valid", 64'(o_valid), 64'd0);
    check("arst_result", o_result, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    run_op("post_rst", 4'd13, 64'd100, 64'd7, 64'd14, 33, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
